// File: rtl/hack_cpu.sv
// hack_cpu: Hack ISA core with a WAIT/FETCH/DECODE/EXEC FSM that hides the one-cycle ROM/RAM read latency.
// Optional halt-loop detection (self-jump to the previous address) is built when HACK_CPU_HALT_EN is defined.
module hack_cpu (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rom_ready,
    output logic [15:0] rom_address,
    input  logic [15:0] instruction,
    output logic [14:0] mem_address,
    input  logic [15:0] mem_din,
    output logic [15:0] mem_dout,
    output logic        mem_write,
    output logic        halted
);

`ifdef HACK_CPU_HALT_EN
    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_EXEC   = 2'd3
    } state_t;
`endif

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] a_r;
    logic [15:0] d_r;
    logic [15:0] ir_r;
    logic [14:0] pc_r;

    logic [15:0] x_zero_s;
    logic [15:0] x_s;
    logic [15:0] y_src_s;
    logic [15:0] y_zero_s;
    logic [15:0] y_s;
    logic [15:0] sum_s;
    logic [15:0] alu_s;
    logic        zr_s;
    logic        ng_s;
    logic        taken_s;
    logic        unused_s;
`ifdef HACK_CPU_HALT_EN
    logic [14:0] pc_prev_s;
    logic        halt_hit_s;
`endif

    // Opcode bits 15:13 carry no information once the instruction is known to be a C-instruction.
    assign unused_s = ^ir_r[15:13];

    // ALU and jump evaluation on the latched C-instruction; readers see pre-EXEC A/D values.
    always_comb begin
        x_zero_s = ir_r[11] ? 16'h0000 : d_r;
        x_s      = ir_r[10] ? ~x_zero_s : x_zero_s;
        y_src_s  = ir_r[12] ? mem_din : a_r;
        y_zero_s = ir_r[9] ? 16'h0000 : y_src_s;
        y_s      = ir_r[8] ? ~y_zero_s : y_zero_s;
        sum_s    = ir_r[7] ? (x_s + y_s) : (x_s & y_s);
        alu_s    = ir_r[6] ? ~sum_s : sum_s;
        zr_s     = (alu_s == 16'h0000);
        ng_s     = alu_s[15];
        taken_s  = (ir_r[2] & ng_s) | (ir_r[1] & zr_s) | (ir_r[0] & ~ng_s & ~zr_s);
    end

`ifdef HACK_CPU_HALT_EN
    // An unconditional jump back to the @-instruction that loaded its own target is a halt loop.
    always_comb begin
        pc_prev_s  = pc_r - 15'd1;
        halt_hit_s = taken_s && (ir_r[2:0] == 3'b111) && (a_r[14:0] == pc_prev_s);
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_WAIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; rom_ready only matters before the first fetch.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_WAIT: begin
                if (rom_ready) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_FETCH: state_next_s = ST_DECODE;
            ST_DECODE: begin
                if (instruction[15]) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
`ifdef HACK_CPU_HALT_EN
                if (halt_hit_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
`else
                state_next_s = ST_FETCH;
`endif
            end
`ifdef HACK_CPU_HALT_EN
            ST_HALT: state_next_s = ST_HALT;
`endif
            default: state_next_s = ST_WAIT;
        endcase
    end

    // FSM outputs; write strobe and write data exist only during EXEC.
    always_comb begin
        rom_address = {1'b0, pc_r};
        mem_address = a_r[14:0];
        mem_write   = 1'b0;
        mem_dout    = 16'h0000;
        halted      = 1'b0;
        case (state_r)
            ST_EXEC: begin
                mem_write = ir_r[3];
                mem_dout  = alu_s;
            end
`ifdef HACK_CPU_HALT_EN
            ST_HALT: halted = 1'b1;
`endif
            default: begin
                mem_write = 1'b0;
            end
        endcase
    end

    // Architectural registers: A/pc load in DECODE for @-instructions, A/D/pc commit together at end of EXEC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_r  <= 16'h0000;
            d_r  <= 16'h0000;
            pc_r <= 15'h0000;
            ir_r <= 16'h0000;
        end else begin
            case (state_r)
                ST_DECODE: begin
                    ir_r <= instruction;
                    if (!instruction[15]) begin
                        a_r  <= instruction;
                        pc_r <= pc_r + 15'd1;
                    end else begin
                        a_r  <= a_r;
                        pc_r <= pc_r;
                    end
                end
                ST_EXEC: begin
                    if (ir_r[5]) begin
                        a_r <= alu_s;
                    end else begin
                        a_r <= a_r;
                    end
                    if (ir_r[4]) begin
                        d_r <= alu_s;
                    end else begin
                        d_r <= d_r;
                    end
                    pc_r <= taken_s ? a_r[14:0] : (pc_r + 15'd1);
                end
                default: begin
                    ir_r <= ir_r;
                end
            endcase
        end
    end

endmodule

// File: doc/hack_cpu.md
# hack_cpu

Hack CPU core sitting directly downstream of the program ROM loader: presents a program counter as the ROM address, consumes the returned 16-bit instruction, and executes it against the A/D registers and the data RAM. It stays idle until the ROM reports `rom_ready`, then runs a 3-phase multi-cycle FSM that hides the one-cycle read latency of the SPRAM-backed ROM and data memory. Intended to be instantiated at top level between the ROM loader and the data RAM/memory-mapped I/O.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rom_ready`  in  1  ROM loaded; instructions valid.
- `rom_address`  out  16  PC; bit 15 always 0.
- `instruction`  in  16  ROM word for the address presented on the previous cycle.
- `mem_address`  out  15  always `A[14:0]`.
- `mem_din`  in  16  data RAM read value; valid one cycle after `mem_address` changes.
- `mem_dout`  out  16  ALU result; write data.
- `mem_write`  out  1  write strobe, one cycle per M-destination instruction.
- `halted`  out  1  halt loop detected (see Configuration).

## Operation
- Registers: `A`[15:0], `D`[15:0], `pc`[14:0], `ir`[15:0], FSM state.
- States: WAIT, FETCH, DECODE, EXEC, HALT (HALT only with macro).
- WAIT: `rom_ready`=1 -> FETCH. `rom_ready` is sampled only in WAIT and ignored afterwards.
- FETCH: `rom_address`=pc -> DECODE.
- DECODE: `ir`<=`instruction`.
  - Bit 15=0 (A-instruction): `A`<=instruction, `pc`<=pc+1, -> FETCH.
  - Bit 15=1 (C-instruction): -> EXEC.
- EXEC: decodes from `ir`.
  - Fields: a=`ir[12]`; zx,nx,zy,ny,f,no=`ir[11:6]`; dest A,D,M=`ir[5:3]`; jump lt,eq,gt=`ir[2:0]`. `ir[14:13]` are ignored.
  - ALU: x=`D`, y = a ? `mem_din` : `A`.
    - zx zeroes x; nx inverts x; zy/ny likewise for y.
    - f=1 gives x+y mod 2^16, f=0 gives x&y.
    - no inverts the result.
  - Flags: zr = (out==0), ng = out[15].
  - Jump taken = (lt&ng) | (eq&zr) | (gt&!ng&!zr).
  - `pc` <= taken ? `A[14:0]` (old A) : pc+1. pc wraps 0x7FFF -> 0x0000.
  - `mem_write`=M dest; `mem_address` = old A.
  - A/D dests update at end of EXEC, simultaneously; all readers in EXEC see old values.
  - -> FETCH (or HALT).
- `mem_din` coherence: A changes only at end of DECODE/EXEC. At least one FETCH cycle precedes the next EXEC, so `mem_din` is always valid in EXEC.

## Timing
- Reset (async assert, sync release): state=WAIT, A=D=pc=ir=0, `rom_address`=0, `mem_address`=0, `mem_dout`=0, `mem_write`=0, `halted`=0.
- Latency:
  - First FETCH one cycle after `rom_ready` is seen high in WAIT.
  - A-instruction: 2 cycles (FETCH, DECODE).
  - C-instruction: 3 cycles (FETCH, DECODE, EXEC).
- `mem_write` is combinational from state==EXEC & `ir[3]`: high exactly one cycle, with `mem_dout`/`mem_address` stable that cycle.
- `mem_dout` = ALU output combinationally; 0 outside EXEC.
- Reset mid-instruction: immediate return to reset values; a pending write is dropped.

## Configuration
- `HACK_CPU_HALT_EN` defined:
  - In EXEC, taken jump with jump=111 and `A[14:0]`==pc-1 (mod 2^15) enters HALT.
  - HALT: `halted`=1; pc, A, D frozen; no writes; exit only by reset.
  - Side effects of the halting instruction (dest writes) still complete.
- Undefined: HALT state absent, `halted` tied 0, the loop executes forever.

## Test plan
- Boot gating: hold `rom_ready`=0 for 50 cycles -> `rom_address`=0, no `mem_write`. Raise it -> FETCH next cycle.
- A/D path: ROM `@0x1234; D=A (0xEC10); @0x0010; M=D (0xE308)` -> single `mem_write` pulse with `mem_address`=0x0010, `mem_dout`=0x1234.
- M read: RAM[5]=7, ROM `@5; D=M+1 (0xFDD0)` -> D=8. Cycle count from first FETCH = 5.
- Jump: D=1, ROM `@10; D;JGT (0xE301)` -> next `rom_address`=10. With D=0 -> next `rom_address`=2.
- Simultaneous dest: A=3, ROM `AM=A+1 (0xEDE8)` -> write to address 3 with data 4, then A=4.
- Halt loop (macro on): `@4` at address 4, `0;JMP (0xEA87)` at 5 -> `halted`=1, pc frozen at 4. Assert `reset_n`=0 mid-run -> all outputs 0 immediately.
